// File: rtl/aurora_frame_pkg.sv
// Shared types, constants and the per-lane BytesToSend code for the multilane frame packer.
`ifndef AURORA_DEFINITIONS_SV
`include "aurora_definitions.sv"
`endif

package aurora_frame_pkg;

    typedef enum logic [2:0] {
        ST_NOT_READY,
        ST_IDLE,
        ST_DATA,
        ST_SEND_EOF,
        ST_TRUNC,
        ST_DISCARD
    } state_t;

    localparam int MAX_LANES = 32;

    localparam logic [3:0] BYTES_FULL    = `FULL_DATA;
    localparam logic [3:0] BYTES_HALF    = 4'b0100;
    localparam logic [3:0] BYTES_DISABLE = `DISABLE_DATA;
    localparam logic [3:0] BYTES_SEP     = 4'h0;

    // Separator block codes: lane 0 carries the separator, every other lane is idle.
    localparam logic [MAX_LANES-1:0][3:0] SEP_BLOCK = {{(MAX_LANES-1){`DISABLE_DATA}}, 4'h0};

    // The separator sits in the first lane after the last lane holding any data.
    function automatic logic [3:0] lane_bytes(input logic [2*MAX_LANES-1:0] mask, input int l);
        logic [3:0] code;
        if (mask[2*l+1]) begin
            code = BYTES_FULL;
        end else if (mask[2*l]) begin
            code = BYTES_HALF;
        end else if (l == 0) begin
            code = BYTES_SEP;
        end else if (!mask[2*l-2]) begin
            code = BYTES_DISABLE;
        end else begin
            code = BYTES_SEP;
        end
        return code;
    endfunction

endpackage

// File: rtl/aurora_bytes_to_send_enc.sv
// Combinational FIFO word mask to per-lane BytesToSend code encoder.
module aurora_bytes_to_send_enc
    import aurora_frame_pkg::*;
#(
    parameter int NUM_LANES = 4
) (
    input  logic [2*NUM_LANES-1:0]     mask,
    output logic [NUM_LANES-1:0][3:0]  bytes
);

    logic [2*MAX_LANES-1:0] mask_ext;

    assign mask_ext = (2*MAX_LANES)'(mask);

    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            assign bytes[gi] = lane_bytes(mask_ext, gi);
        end
    endgenerate

endmodule

// File: rtl/aurora_definitions.sv
// Aurora 64b/66b BytesToSend lane codes shared by the packer and lane gearboxes.
`ifndef AURORA_DEFINITIONS_SV
`define AURORA_DEFINITIONS_SV

`define FULL_DATA    4'b1000
`define DISABLE_DATA 4'b1111

`endif

// File: rtl/aurora_multilane_frame_packer.sv
// Packs show-ahead FIFO entries into NUM_LANES x 64-bit blocks behind a valid/ready output register,
// with frame truncation/discard, channel-down flush, and frame/drop counters.
module aurora_multilane_frame_packer
    import aurora_frame_pkg::*;
#(
    parameter int NUM_LANES        = 4,
    parameter int MAX_FRAME_BLOCKS = 256,
    parameter int CNT_W            = 16
) (
    input  logic                           Clk,
    input  logic                           Rst_n,
    input  logic                           LaneReady,
    input  logic                           FIFO_Empty,
    input  logic [2*NUM_LANES-1:0][31:0]   FIFO_Data,
    input  logic [2*NUM_LANES-1:0]         FIFO_DataMask,
    input  logic                           EndOfFrame,
    input  logic [2*NUM_LANES-1:0]         CompleteDataMask,
    input  logic                           BlockSent,
    output logic                           FIFO_Read,
    output logic [NUM_LANES-1:0][63:0]     DataToSend,
    output logic [NUM_LANES-1:0][3:0]      BytesToSend,
    output logic                           SendBlock,
    output logic                           Truncated,
    output logic [CNT_W-1:0]               FrameCount,
    output logic [CNT_W-1:0]               DroppedWords
);

    localparam bit TRUNC_EN = (MAX_FRAME_BLOCKS > 0);
    localparam int BLK_W    = TRUNC_EN ? $clog2(MAX_FRAME_BLOCKS + 1) : 1;
    localparam logic [BLK_W-1:0] TRUNC_AT = BLK_W'(TRUNC_EN ? MAX_FRAME_BLOCKS - 1 : 0);
    localparam logic [NUM_LANES-1:0][3:0] SEP_BYTES = SEP_BLOCK[NUM_LANES-1:0];

    state_t                        state_reg, state_next;
    logic [BLK_W-1:0]              blk_cnt_reg, blk_cnt_next;
    logic                          mid_frame_reg, mid_frame_next;
    logic                          send_block_reg, send_block_next;
    logic [NUM_LANES-1:0][63:0]    data_reg, data_next;
    logic [NUM_LANES-1:0][3:0]     bytes_reg, bytes_next;
    logic                          eof_blk_reg, eof_blk_next;
    logic [CNT_W-1:0]              frame_count_reg, dropped_reg;

    logic [NUM_LANES-1:0][3:0]     entry_bytes;
    logic                          slot_free;
    logic                          pop, drop, truncated;
    logic                          load_data, load_sep, ends_frame;

    aurora_bytes_to_send_enc #(
        .NUM_LANES (NUM_LANES)
    ) u_enc (
        .mask  (FIFO_DataMask),
        .bytes (entry_bytes)
    );

    always_comb begin
        slot_free      = ~send_block_reg | BlockSent;
        state_next     = state_reg;
        blk_cnt_next   = blk_cnt_reg;
        mid_frame_next = mid_frame_reg;
        pop            = 1'b0;
        drop           = 1'b0;
        truncated      = 1'b0;
        load_data      = 1'b0;
        load_sep       = 1'b0;
        ends_frame     = 1'b0;

        if (!LaneReady) begin
            state_next   = ST_NOT_READY;
            blk_cnt_next = '0;
            if (state_reg inside {ST_DATA, ST_SEND_EOF, ST_TRUNC, ST_DISCARD}) begin
                mid_frame_next = 1'b1;
            end
        end else begin
            unique case (state_reg)
                ST_NOT_READY: begin
                    blk_cnt_next = '0;
                    state_next   = ST_IDLE;
                end
                ST_IDLE, ST_DATA: begin
                    if (state_reg == ST_IDLE) begin
                        blk_cnt_next = '0;
                    end
                    // A frame cut by a channel drop is flushed up to its EOF before anything new is sent.
                    if (state_reg == ST_IDLE && mid_frame_reg) begin
                        mid_frame_next = 1'b0;
                        state_next     = ST_DISCARD;
                    end else if (slot_free && !FIFO_Empty) begin
                        pop          = 1'b1;
                        load_data    = 1'b1;
                        blk_cnt_next = (state_reg == ST_IDLE) ? BLK_W'(1) : blk_cnt_reg + BLK_W'(1);
                        if (EndOfFrame) begin
                            if (FIFO_DataMask == CompleteDataMask) begin
                                state_next = ST_SEND_EOF;
                            end else begin
                                ends_frame = 1'b1;
                                state_next = ST_IDLE;
                            end
                        end else if (TRUNC_EN && blk_cnt_next >= TRUNC_AT) begin
                            state_next = ST_TRUNC;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end
                end
                ST_SEND_EOF: begin
                    if (slot_free) begin
                        load_sep   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
                ST_TRUNC: begin
                    if (slot_free) begin
                        load_sep   = 1'b1;
                        truncated  = 1'b1;
                        state_next = ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (!FIFO_Empty) begin
                        pop  = 1'b1;
                        drop = 1'b1;
                        if (EndOfFrame) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_NOT_READY;
            endcase
        end
    end

    // Output register: a new load may replace a block that is being accepted in the same cycle.
    always_comb begin
        send_block_next = send_block_reg;
        data_next       = data_reg;
        bytes_next      = bytes_reg;
        eof_blk_next    = eof_blk_reg;
        if (!LaneReady) begin
            send_block_next = 1'b0;
            data_next       = '0;
            bytes_next      = '0;
            eof_blk_next    = 1'b0;
        end else if (load_data) begin
            send_block_next = 1'b1;
            data_next       = FIFO_Data;
            bytes_next      = entry_bytes;
            eof_blk_next    = ends_frame;
        end else if (load_sep) begin
            send_block_next = 1'b1;
            data_next       = '0;
            bytes_next      = SEP_BYTES;
            eof_blk_next    = 1'b1;
        end else if (BlockSent) begin
            send_block_next = 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= ST_NOT_READY;
            blk_cnt_reg     <= '0;
            mid_frame_reg   <= 1'b0;
            send_block_reg  <= 1'b0;
            data_reg        <= '0;
            bytes_reg       <= '0;
            eof_blk_reg     <= 1'b0;
            frame_count_reg <= '0;
            dropped_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            blk_cnt_reg    <= blk_cnt_next;
            mid_frame_reg  <= mid_frame_next;
            send_block_reg <= send_block_next;
            data_reg       <= data_next;
            bytes_reg      <= bytes_next;
            eof_blk_reg    <= eof_blk_next;
            if (send_block_reg && BlockSent && eof_blk_reg) begin
                frame_count_reg <= frame_count_reg + CNT_W'(1);
            end
            if (drop && (dropped_reg != {CNT_W{1'b1}})) begin
                dropped_reg <= dropped_reg + CNT_W'(1);
            end
        end
    end

    assign FIFO_Read    = pop;
    assign DataToSend   = data_reg;
    assign BytesToSend  = bytes_reg;
    assign SendBlock    = send_block_reg;
    assign Truncated    = truncated;
    assign FrameCount   = frame_count_reg;
    assign DroppedWords = dropped_reg;

endmodule

// File: tb/tb_aurora_multilane_frame_packer.sv
// Directed self-checking bench for the 4-lane packer with MAX_FRAME_BLOCKS=4.
module tb_aurora_multilane_frame_packer;

    localparam int NL   = 4;
    localparam int W    = 2 * NL;
    localparam int MAXB = 4;
    localparam int CW   = 16;

    localparam logic [15:0]  SEP_CODES = 16'hFFF0;
    localparam logic [15:0]  ALL_FULL  = 16'h8888;

    logic                  Clk = 1'b0;
    logic                  Rst_n;
    logic                  LaneReady;
    logic                  FIFO_Empty;
    logic [W-1:0][31:0]    FIFO_Data;
    logic [W-1:0]          FIFO_DataMask;
    logic                  EndOfFrame;
    logic [W-1:0]          CompleteDataMask;
    logic                  BlockSent;
    logic                  FIFO_Read;
    logic [NL-1:0][63:0]   DataToSend;
    logic [NL-1:0][3:0]    BytesToSend;
    logic                  SendBlock;
    logic                  Truncated;
    logic [CW-1:0]         FrameCount;
    logic [CW-1:0]         DroppedWords;

    typedef struct {
        logic [W-1:0][31:0] data;
        logic [W-1:0]       mask;
        logic               eof;
    } entry_t;

    entry_t       fifo_q[$];
    logic [255:0] cap_data[$];
    logic [15:0]  cap_bytes[$];
    int           total = 0;
    int           bad = 0;
    int           pops = 0;
    int           trunc_pulses = 0;

    aurora_multilane_frame_packer #(
        .NUM_LANES        (NL),
        .MAX_FRAME_BLOCKS (MAXB),
        .CNT_W            (CW)
    ) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .LaneReady        (LaneReady),
        .FIFO_Empty       (FIFO_Empty),
        .FIFO_Data        (FIFO_Data),
        .FIFO_DataMask    (FIFO_DataMask),
        .EndOfFrame       (EndOfFrame),
        .CompleteDataMask (CompleteDataMask),
        .BlockSent        (BlockSent),
        .FIFO_Read        (FIFO_Read),
        .DataToSend       (DataToSend),
        .BytesToSend      (BytesToSend),
        .SendBlock        (SendBlock),
        .Truncated        (Truncated),
        .FrameCount       (FrameCount),
        .DroppedWords     (DroppedWords)
    );

    always #5 Clk = ~Clk;

    function automatic logic [255:0] make_data(input int id);
        logic [255:0] r;
        for (int w = 0; w < W; w++) begin
            r[32*w +: 32] = {id[15:0], 16'hC000 + 16'(w)};
        end
        return r;
    endfunction

    task automatic refresh_fifo();
        if (fifo_q.size() == 0) begin
            FIFO_Empty    = 1'b1;
            FIFO_Data     = '0;
            FIFO_DataMask = '0;
            EndOfFrame    = 1'b0;
        end else begin
            FIFO_Empty    = 1'b0;
            FIFO_Data     = fifo_q[0].data;
            FIFO_DataMask = fifo_q[0].mask;
            EndOfFrame    = fifo_q[0].eof;
        end
    endtask

    task automatic push(input int id, input logic [W-1:0] mask, input logic eof);
        entry_t e;
        e.data = make_data(id);
        e.mask = mask;
        e.eof  = eof;
        fifo_q.push_back(e);
        refresh_fifo();
    endtask

    // One clock: sample just before the edge, then apply any pop just after it.
    task automatic cycle();
        logic pop_now;
        #2;
        pop_now = FIFO_Read;
        if (FIFO_Read) pops++;
        if (Truncated) trunc_pulses++;
        if (SendBlock && BlockSent) begin
            cap_data.push_back(DataToSend);
            cap_bytes.push_back(BytesToSend);
            $display("block %0d: bytes=%h data[63:0]=%h", cap_data.size() - 1, BytesToSend, DataToSend[0]);
        end
        @(posedge Clk);
        #1;
        if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refresh_fifo();
    endtask

    task automatic drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (fifo_q.size() == 0 && !SendBlock) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_send(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (SendBlock) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        Rst_n = 1'b0;
        LaneReady = 1'b0;
        BlockSent = 1'b0;
        CompleteDataMask = 8'hFF;
        refresh_fifo();
        #1;
        total++; if (SendBlock !== 1'b0) begin bad++; $display("FAIL reset_send got=%b want=0", SendBlock); end
        total++; if (DataToSend !== '0) begin bad++; $display("FAIL reset_data got=%h want=0", DataToSend); end
        total++; if (BytesToSend !== '0) begin bad++; $display("FAIL reset_bytes got=%h want=0", BytesToSend); end
        total++; if (Truncated !== 1'b0) begin bad++; $display("FAIL reset_trunc got=%b want=0", Truncated); end
        total++; if (FrameCount !== '0) begin bad++; $display("FAIL reset_fc got=%0d want=0", FrameCount); end
        total++; if (DroppedWords !== '0) begin bad++; $display("FAIL reset_dw got=%0d want=0", DroppedWords); end
        @(posedge Clk);
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        cycle();
        total++; if (SendBlock !== 1'b0) begin bad++; $display("FAIL notready_send got=%b want=0", SendBlock); end
        LaneReady = 1'b1;
        BlockSent = 1'b1;
        cycle();
        $display("reset test complete");
    endtask

    task automatic test_partial_eof();
        bit ok;
        cap_data.delete();
        cap_bytes.delete();
        push(10, 8'hFF, 1'b0);
        push(11, 8'h07, 1'b1);
        drain(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL t1_timeout got=busy want=drained"); end
        total++; if (cap_data.size() != 2) begin bad++; $display("FAIL t1_count got=%0d want=2", cap_data.size()); end
        if (cap_data.size() >= 2) begin
            total++; if (cap_bytes[0] !== ALL_FULL) begin bad++; $display("FAIL t1_bytes0 got=%h want=%h", cap_bytes[0], ALL_FULL); end
            total++; if (cap_data[0] !== make_data(10)) begin bad++; $display("FAIL t1_data0 got=%h want=%h", cap_data[0], make_data(10)); end
            total++; if (cap_bytes[1] !== 16'hF048) begin bad++; $display("FAIL t1_bytes1 got=%h want=f048", cap_bytes[1]); end
            total++; if (cap_data[1] !== make_data(11)) begin bad++; $display("FAIL t1_data1 got=%h want=%h", cap_data[1], make_data(11)); end
        end
        total++; if (FrameCount !== 16'd1) begin bad++; $display("FAIL t1_fc got=%0d want=1", FrameCount); end
    endtask

    task automatic test_full_eof();
        bit ok;
        cap_data.delete();
        cap_bytes.delete();
        push(20, 8'hFF, 1'b1);
        drain(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL t2_timeout got=busy want=drained"); end
        total++; if (cap_data.size() != 2) begin bad++; $display("FAIL t2_count got=%0d want=2", cap_data.size()); end
        if (cap_data.size() >= 2) begin
            total++; if (cap_bytes[0] !== ALL_FULL) begin bad++; $display("FAIL t2_bytes0 got=%h want=%h", cap_bytes[0], ALL_FULL); end
            total++; if (cap_bytes[1] !== SEP_CODES) begin bad++; $display("FAIL t2_sep_bytes got=%h want=%h", cap_bytes[1], SEP_CODES); end
            total++; if (cap_data[1] !== '0) begin bad++; $display("FAIL t2_sep_data got=%h want=0", cap_data[1]); end
        end
        total++; if (FrameCount !== 16'd2) begin bad++; $display("FAIL t2_fc got=%0d want=2", FrameCount); end
    endtask

    task automatic test_back_pressure();
        bit ok;
        int pops0;
        int unstable;
        cap_data.delete();
        cap_bytes.delete();
        BlockSent = 1'b0;
        pops0 = pops;
        unstable = 0;
        push(30, 8'hFF, 1'b0);
        push(31, 8'hFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (i > 0 && (DataToSend !== make_data(30) || SendBlock !== 1'b1)) unstable++;
        end
        total++; if (pops - pops0 != 1) begin bad++; $display("FAIL t3_pops got=%0d want=1", pops - pops0); end
        total++; if (unstable != 0) begin bad++; $display("FAIL t3_stable got=%0d changes want=0", unstable); end
        BlockSent = 1'b1;
        drain(30, ok);
        total++; if (!ok) begin bad++; $display("FAIL t3_timeout got=busy want=drained"); end
        total++; if (cap_data.size() != 3) begin bad++; $display("FAIL t3_count got=%0d want=3", cap_data.size()); end
        if (cap_data.size() >= 3) begin
            total++; if (cap_data[0] !== make_data(30)) begin bad++; $display("FAIL t3_data0 got=%h want=%h", cap_data[0], make_data(30)); end
            total++; if (cap_data[1] !== make_data(31)) begin bad++; $display("FAIL t3_data1 got=%h want=%h", cap_data[1], make_data(31)); end
            total++; if (cap_bytes[2] !== SEP_CODES) begin bad++; $display("FAIL t3_sep got=%h want=%h", cap_bytes[2], SEP_CODES); end
        end
        total++; if (FrameCount !== 16'd3) begin bad++; $display("FAIL t3_fc got=%0d want=3", FrameCount); end
    endtask

    task automatic test_truncation();
        bit ok;
        int tp0;
        cap_data.delete();
        cap_bytes.delete();
        tp0 = trunc_pulses;
        for (int i = 0; i < 10; i++) push(40 + i, 8'hFF, (i == 9));
        drain(60, ok);
        total++; if (!ok) begin bad++; $display("FAIL t4_timeout got=busy want=drained"); end
        total++; if (cap_data.size() != 4) begin bad++; $display("FAIL t4_count got=%0d want=4", cap_data.size()); end
        if (cap_data.size() >= 4) begin
            total++; if (cap_data[2] !== make_data(42)) begin bad++; $display("FAIL t4_data2 got=%h want=%h", cap_data[2], make_data(42)); end
            total++; if (cap_bytes[3] !== SEP_CODES) begin bad++; $display("FAIL t4_sep got=%h want=%h", cap_bytes[3], SEP_CODES); end
        end
        total++; if (trunc_pulses - tp0 != 1) begin bad++; $display("FAIL t4_trunc_pulses got=%0d want=1", trunc_pulses - tp0); end
        total++; if (DroppedWords !== 16'd7) begin bad++; $display("FAIL t4_dropped got=%0d want=7", DroppedWords); end
        total++; if (FrameCount !== 16'd4) begin bad++; $display("FAIL t4_fc got=%0d want=4", FrameCount); end
    endtask

    task automatic test_lane_drop();
        bit ok;
        cap_data.delete();
        cap_bytes.delete();
        push(50, 8'hFF, 1'b0);
        push(51, 8'hFF, 1'b0);
        push(52, 8'hFF, 1'b1);
        wait_send(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_start got=idle want=sending"); end
        LaneReady = 1'b0;
        BlockSent = 1'b0;
        #1;
        total++; if (FIFO_Read !== 1'b0) begin bad++; $display("FAIL t5_no_pop got=%b want=0", FIFO_Read); end
        cycle();
        total++; if (SendBlock !== 1'b0) begin bad++; $display("FAIL t5_send_low got=%b want=0", SendBlock); end
        total++; if (DataToSend !== '0) begin bad++; $display("FAIL t5_data_clr got=%h want=0", DataToSend); end
        LaneReady = 1'b1;
        BlockSent = 1'b1;
        push(60, 8'hFF, 1'b1);
        drain(40, ok);
        total++; if (!ok) begin bad++; $display("FAIL t5_timeout got=busy want=drained"); end
        total++; if (cap_data.size() != 2) begin bad++; $display("FAIL t5_count got=%0d want=2", cap_data.size()); end
        if (cap_data.size() >= 2) begin
            total++; if (cap_data[0] !== make_data(60)) begin bad++; $display("FAIL t5_next_frame got=%h want=%h", cap_data[0], make_data(60)); end
            total++; if (cap_bytes[1] !== SEP_CODES) begin bad++; $display("FAIL t5_sep got=%h want=%h", cap_bytes[1], SEP_CODES); end
        end
        total++; if (DroppedWords !== 16'd9) begin bad++; $display("FAIL t5_dropped got=%0d want=9", DroppedWords); end
        total++; if (FrameCount !== 16'd5) begin bad++; $display("FAIL t5_fc got=%0d want=5", FrameCount); end
    endtask

    task automatic test_async_reset();
        bit ok;
        BlockSent = 1'b0;
        push(70, 8'hFF, 1'b1);
        wait_send(10, ok);
        total++; if (!ok) begin bad++; $display("FAIL t6_start got=idle want=sending"); end
        #2;
        Rst_n = 1'b0;
        #1;
        total++; if (SendBlock !== 1'b0) begin bad++; $display("FAIL t6_send got=%b want=0", SendBlock); end
        total++; if (FrameCount !== '0) begin bad++; $display("FAIL t6_fc got=%0d want=0", FrameCount); end
        total++; if (DroppedWords !== '0) begin bad++; $display("FAIL t6_dw got=%0d want=0", DroppedWords); end
        total++; if (DataToSend !== '0) begin bad++; $display("FAIL t6_data got=%h want=0", DataToSend); end
        fifo_q.delete();
        refresh_fifo();
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_partial_eof();
        test_full_eof();
        test_back_pressure();
        test_truncation();
        test_lane_drop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
